// File: rtl/regbank_write_ctrl.sv
// ============================================================================
// Module   : regbank_write_ctrl
// Purpose  : 32-entry register bank write side with a one-stage commit pipe and a sequential bank clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regbank_write_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Wr_valid,
  output logic             Wr_ready,
  input  logic [4:0]       Wr_addr,
  input  logic [WIDTH-1:0] Wr_data,
  input  logic             Clr_start,
  output logic             Busy,
  output logic             Clr_done,
  output logic [WIDTH-1:0] Q0,  Q1,  Q2,  Q3,  Q4,  Q5,  Q6,  Q7,
  output logic [WIDTH-1:0] Q8,  Q9,  Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [WIDTH-1:0] Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [WIDTH-1:0] Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             stage_valid;
  logic [4:0]       stage_addr;
  logic [WIDTH-1:0] stage_data;
  logic [4:0]       clr_count;
  logic             clr_done_r;
  logic             accept;
  logic [31:0]      wr_en;
  logic [31:0]      clr_en;
  logic [WIDTH-1:0] bank [32];

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A pending or just-accepted write must land before the clear sweeps past it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Clr_start) state_nxt = (stage_valid || accept) ? S_DRAIN : S_CLEAR;
      S_DRAIN: state_nxt = S_CLEAR;
      S_CLEAR: if (clr_count == 5'd31) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Wr_ready = (state == S_IDLE);
    Busy     = (state != S_IDLE);
  end

  assign accept   = Wr_valid && Wr_ready;
  assign Clr_done = clr_done_r;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      clr_count   <= '0;
      clr_done_r  <= 1'b0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_addr <= Wr_addr;
        stage_data <= Wr_data;
      end
      if (state == S_CLEAR) clr_count <= clr_count + 5'd1;
      clr_done_r <= (state == S_CLEAR) && (clr_count == 5'd31);
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_decode
    assign wr_en[i]  = stage_valid && (stage_addr == 5'(i)) && !(ZERO_REG && (i == 0));
    assign clr_en[i] = (state == S_CLEAR) && (clr_count == 5'(i));
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 32; i++) begin
      if (Reset)          bank[i] <= '0;
      else if (clr_en[i]) bank[i] <= '0;
      else if (wr_en[i])  bank[i] <= stage_data;
    end
  end

  assign Q0  = bank[0];   assign Q1  = bank[1];   assign Q2  = bank[2];   assign Q3  = bank[3];
  assign Q4  = bank[4];   assign Q5  = bank[5];   assign Q6  = bank[6];   assign Q7  = bank[7];
  assign Q8  = bank[8];   assign Q9  = bank[9];   assign Q10 = bank[10];  assign Q11 = bank[11];
  assign Q12 = bank[12];  assign Q13 = bank[13];  assign Q14 = bank[14];  assign Q15 = bank[15];
  assign Q16 = bank[16];  assign Q17 = bank[17];  assign Q18 = bank[18];  assign Q19 = bank[19];
  assign Q20 = bank[20];  assign Q21 = bank[21];  assign Q22 = bank[22];  assign Q23 = bank[23];
  assign Q24 = bank[24];  assign Q25 = bank[25];  assign Q26 = bank[26];  assign Q27 = bank[27];
  assign Q28 = bank[28];  assign Q29 = bank[29];  assign Q30 = bank[30];  assign Q31 = bank[31];

endmodule

`default_nettype wire
